pmod_ble_ctrl: RTL and testbench
================================

PMOD_BLE_CTRL -- requirements
Module: pmod_ble_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (115200 baud at 100 MHz).
REQ-002 SHALL have parameter RST_CYCLES, default 10000, meaning cycles io_pmod_rstn is held low.
REQ-003 SHALL have parameter BOOT_CYCLES, default 5000000, meaning cycles waited after rstn release before the module is ready.
REQ-004 SHALL have parameter IDLE_BITS, default 11, meaning bit times of continuous host-line high required before CPU takeover.
REQ-005 SHALL have port clk  input  1  system clock; the only clock.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_uart_rx  input  1  serial data from host computer.
REQ-008 SHALL have port o_uart_tx  output  1  serial data to host computer.
REQ-009 SHALL have port io_pmod_rxd  output  1  RN4871 RX line (pin 2), driven by FPGA.
REQ-010 SHALL have port io_pmod_txd  input  1  RN4871 TX line (pin 3).
REQ-011 SHALL have port io_pmod_rstn  output  1  RN4871 active-low reset (pin 8).
REQ-012 SHALL have ports i_ble_reset_req  input  1  one-cycle request to restart the reset sequence; i_mode_cpu  input  1  level, 1 requests CPU ownership of io_pmod_rxd.
REQ-013 SHALL have ports i_cpu_tx_data  input  8  byte to send; i_cpu_tx_valid  input  1; o_cpu_tx_ready  output  1.
REQ-014 SHALL have ports o_ble_ready  output  1  module booted; o_owner_cpu  output  1  current owner is CPU; o_cpu_rx_data  output  8; o_cpu_rx_valid  output  1.

Function
REQ-015 SHALL implement sequencer states RST_ASSERT -> BOOT_WAIT -> ACTIVE; RST_ASSERT lasts exactly RST_CYCLES cycles with io_pmod_rstn=0, BOOT_WAIT lasts exactly BOOT_CYCLES cycles with io_pmod_rstn=1, ACTIVE holds indefinitely.
REQ-016 SHALL assert o_ble_ready only in ACTIVE (registered, first high on the first ACTIVE cycle).
REQ-017 SHALL, on i_ble_reset_req in any state, enter RST_ASSERT next cycle with counter cleared, abort any in-flight CPU byte, force owner to host and deassert o_ble_ready.
REQ-018 SHALL drive o_uart_tx = io_pmod_txd combinationally at all times.
REQ-019 SHALL drive io_pmod_rxd = 1 outside ACTIVE; in ACTIVE, i_uart_rx when owner is host, else CPU serializer output (idle high).
REQ-020 SHALL switch host->CPU only when i_mode_cpu=1, in ACTIVE, and i_uart_rx has been high for IDLE_BITS*CLKS_PER_BIT consecutive cycles; the idle counter saturates and clears on any low sample.
REQ-021 SHALL switch CPU->host only when i_mode_cpu=0 and the serializer is idle; a byte in flight completes first.
REQ-022 SHALL assert o_cpu_tx_ready when ACTIVE, owner is CPU, i_mode_cpu=1 and serializer idle; transfer occurs on valid&&ready.
REQ-023 SHALL serialize each accepted byte starting the next cycle: start bit 0, data LSB-first, stop bit 1, each exactly CLKS_PER_BIT cycles (10*CLKS_PER_BIT total); ready stays low until the stop bit ends.
REQ-024 SHALL ignore i_cpu_tx_valid while ready is low (no buffering, byte not latched).

Reset
REQ-025 SHALL on rst: state RST_ASSERT, counters 0, io_pmod_rstn=0, io_pmod_rxd=1, owner host, o_owner_cpu=0, o_ble_ready=0, o_cpu_tx_ready=0, o_cpu_rx_data=0, o_cpu_rx_valid=0.
REQ-026 SHALL treat rst mid-byte or mid-sequence identically to REQ-025; sequence restarts from RST_ASSERT after rst deasserts.

Configuration
REQ-027 SHALL, with PMOD_BLE_RXCAP_EN defined, include a receiver on io_pmod_txd: 2-flop synchronizer, start-bit detect, mid-bit sampling, o_cpu_rx_data updated and o_cpu_rx_valid pulsed one cycle per byte with valid stop bit; bytes with stop bit 0 dropped.
REQ-028 SHALL, without PMOD_BLE_RXCAP_EN, tie o_cpu_rx_data=0 and o_cpu_rx_valid=0 with no receiver logic.

Verification (CLKS_PER_BIT=4, RST_CYCLES=8, BOOT_CYCLES=16, IDLE_BITS=11)
REQ-029 SHALL cover: rst released at cycle 0 -> rstn low cycles 0-7, high from 8, o_ble_ready high at cycle 24.
REQ-030 SHALL cover: ACTIVE, i_mode_cpu=1, i_uart_rx high 44 cycles -> o_owner_cpu=1; line toggled low at cycle 40 -> no switch until 44 further high cycles.
REQ-031 SHALL cover: CPU owner, send 0xA5 -> io_pmod_rxd 0,1,0,1,0,0,1,0,1,1 each 4 cycles, ready low 40 cycles.
REQ-032 SHALL cover: i_mode_cpu drops mid-byte -> byte completes, owner returns to host on first idle cycle.
REQ-033 SHALL cover: i_ble_reset_req mid-byte -> io_pmod_rxd=1 and rstn=0 next cycle, o_owner_cpu=0.
REQ-034 SHALL cover (PMOD_BLE_RXCAP_EN): 0x3C on io_pmod_txd -> single o_cpu_rx_valid pulse, data 0x3C, o_uart_tx mirrors line.

Source files
------------

// File: rtl/pmod_ble_ctrl_if.sv
// CPU-side byte handshake of the RN4871 PMOD controller: transmit request/ready
// toward the module and captured receive bytes back to the CPU.
interface pmod_ble_ctrl_if;
   logic [7:0] i_cpu_tx_data;
   logic       i_cpu_tx_valid;
   logic       o_cpu_tx_ready;
   logic [7:0] o_cpu_rx_data;
   logic       o_cpu_rx_valid;

   modport master (
      output i_cpu_tx_data, i_cpu_tx_valid,
      input  o_cpu_tx_ready, o_cpu_rx_data, o_cpu_rx_valid
   );

   modport slave (
      input  i_cpu_tx_data, i_cpu_tx_valid,
      output o_cpu_tx_ready, o_cpu_rx_data, o_cpu_rx_valid
   );
endinterface

// File: rtl/pmod_ble_ctrl.sv
// RN4871 PMOD controller: reset/boot sequencer, host/CPU arbitration of the module RX
// line, CPU UART serializer; optional receiver on the module TX line (PMOD_BLE_RXCAP_EN).
module pmod_ble_ctrl #(
   parameter int CLKS_PER_BIT = 868,
   parameter int RST_CYCLES   = 10000,
   parameter int BOOT_CYCLES  = 5000000,
   parameter int IDLE_BITS    = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_uart_rx,
   output logic              o_uart_tx,
   output logic              io_pmod_rxd,
   input  logic              io_pmod_txd,
   output logic              io_pmod_rstn,
   input  logic              i_ble_reset_req,
   input  logic              i_mode_cpu,
   output logic              o_ble_ready,
   output logic              o_owner_cpu,
   pmod_ble_ctrl_if.slave    cpu
);

   localparam int SEQ_MAX  = (RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES;
   localparam int SEQ_W    = $clog2(SEQ_MAX + 1);
   localparam int BAUD_W   = $clog2(CLKS_PER_BIT + 1);
   localparam int IDLE_TGT = IDLE_BITS * CLKS_PER_BIT;
   localparam int IDLE_W   = $clog2(IDLE_TGT + 1);

   localparam logic [SEQ_W-1:0]  RST_LAST  = SEQ_W'(RST_CYCLES - 1);
   localparam logic [SEQ_W-1:0]  BOOT_LAST = SEQ_W'(BOOT_CYCLES - 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_TGT);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TGT - 1);

   typedef enum logic [1:0] {
      RST_ASSERT = 2'd0,
      BOOT_WAIT  = 2'd1,
      ACTIVE     = 2'd2
   } seq_state_e;

   seq_state_e        state_q;
   logic [SEQ_W-1:0]  seq_cnt_q;
   logic              rstn_q;
   logic              ble_ready_q;
   logic              owner_q;
   logic [IDLE_W-1:0] idle_cnt_q;
   logic              busy_q;
   logic [9:0]        shift_q;
   logic [BAUD_W-1:0] baud_cnt_q;
   logic [3:0]        bit_cnt_q;

   logic active_d;
   logic tx_ready_d;
   logic idle_full_d;

   assign active_d    = (state_q == ACTIVE);
   assign tx_ready_d  = active_d && owner_q && i_mode_cpu && !busy_q;
   // True when this sample completes the required run of high host-line cycles.
   assign idle_full_d = i_uart_rx && (idle_cnt_q >= IDLE_LAST);

   assign o_uart_tx          = io_pmod_txd;
   assign io_pmod_rxd        = active_d ? (owner_q ? shift_q[0] : i_uart_rx) : 1'b1;
   assign io_pmod_rstn       = rstn_q;
   assign o_ble_ready        = ble_ready_q;
   assign o_owner_cpu        = owner_q;
   assign cpu.o_cpu_tx_ready = tx_ready_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RST_ASSERT;
         seq_cnt_q   <= '0;
         rstn_q      <= 1'b0;
         ble_ready_q <= 1'b0;
         owner_q     <= 1'b0;
         idle_cnt_q  <= '0;
         busy_q      <= 1'b0;
         shift_q     <= '1;
         baud_cnt_q  <= '0;
         bit_cnt_q   <= '0;
      end else begin
         if (!i_uart_rx) begin
            idle_cnt_q <= '0;
         end else if (idle_cnt_q != IDLE_SAT) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
         end

         if (i_ble_reset_req) begin
            state_q     <= RST_ASSERT;
            seq_cnt_q   <= '0;
            rstn_q      <= 1'b0;
            ble_ready_q <= 1'b0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            shift_q     <= '1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
         end else begin
            case (state_q)
               RST_ASSERT: begin
                  if (seq_cnt_q == RST_LAST) begin
                     state_q   <= BOOT_WAIT;
                     seq_cnt_q <= '0;
                     rstn_q    <= 1'b1;
                  end else begin
                     seq_cnt_q <= seq_cnt_q + 1'b1;
                  end
               end
               BOOT_WAIT: begin
                  if (seq_cnt_q == BOOT_LAST) begin
                     state_q     <= ACTIVE;
                     seq_cnt_q   <= '0;
                     ble_ready_q <= 1'b1;
                  end else begin
                     seq_cnt_q <= seq_cnt_q + 1'b1;
                  end
               end
               default: ;
            endcase

            // A byte in flight always finishes before the line goes back to the host.
            if (!owner_q) begin
               if (active_d && i_mode_cpu && idle_full_d) owner_q <= 1'b1;
            end else if (!i_mode_cpu && !busy_q) begin
               owner_q <= 1'b0;
            end

            if (tx_ready_d && cpu.i_cpu_tx_valid) begin
               busy_q     <= 1'b1;
               shift_q    <= {1'b1, cpu.i_cpu_tx_data, 1'b0};
               baud_cnt_q <= '0;
               bit_cnt_q  <= '0;
            end else if (busy_q) begin
               if (baud_cnt_q == BAUD_LAST) begin
                  baud_cnt_q <= '0;
                  shift_q    <= {1'b1, shift_q[9:1]};
                  if (bit_cnt_q == 4'd9) begin
                     busy_q <= 1'b0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
         end
      end
   end

`ifdef PMOD_BLE_RXCAP_EN
   localparam logic [BAUD_W-1:0] HALF_LAST = (CLKS_PER_BIT / 2 > 0) ?
                                              BAUD_W'(CLKS_PER_BIT / 2 - 1) : '0;

   logic [1:0]        rx_sync_q;
   logic              rx_busy_q;
   logic [BAUD_W-1:0] rx_baud_q;
   logic [3:0]        rx_bit_q;
   logic [7:0]        rx_shift_q;
   logic [7:0]        rx_data_q;
   logic              rx_valid_q;
   logic              rx_line_d;

   assign rx_line_d          = rx_sync_q[1];
   assign cpu.o_cpu_rx_data  = rx_data_q;
   assign cpu.o_cpu_rx_valid = rx_valid_q;

   // Bit index 0 re-checks the start bit at mid-bit, 1..8 are data, 9 is the stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync_q  <= 2'b11;
         rx_busy_q  <= 1'b0;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], io_pmod_txd};
         rx_valid_q <= 1'b0;
         if (!rx_busy_q) begin
            if (!rx_line_d) begin
               rx_busy_q <= 1'b1;
               rx_baud_q <= HALF_LAST;
               rx_bit_q  <= '0;
            end
         end else if (rx_baud_q != '0) begin
            rx_baud_q <= rx_baud_q - 1'b1;
         end else begin
            rx_baud_q <= BAUD_LAST;
            rx_bit_q  <= rx_bit_q + 1'b1;
            if (rx_bit_q == 4'd0) begin
               if (rx_line_d) rx_busy_q <= 1'b0;
            end else if (rx_bit_q == 4'd9) begin
               rx_busy_q <= 1'b0;
               if (rx_line_d) begin
                  rx_data_q  <= rx_shift_q;
                  rx_valid_q <= 1'b1;
               end
            end else begin
               rx_shift_q <= {rx_line_d, rx_shift_q[7:1]};
            end
         end
      end
   end
`else
   assign cpu.o_cpu_rx_data  = '0;
   assign cpu.o_cpu_rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pmod_ble_ctrl.sv
// Randomized directed bench for pmod_ble_ctrl against a cycle-level behavioural model
// (sequence position, host-line run length, queue of expected serial line values).
module tb_pmod_ble_ctrl;
   localparam int CPB   = 4;
   localparam int RSTC  = 8;
   localparam int BOOTC = 16;
   localparam int IDLEB = 11;

   logic clk = 1'b0;
   logic rst;
   logic uart_rx;
   logic uart_tx;
   logic pmod_rxd;
   logic pmod_txd;
   logic pmod_rstn;
   logic reset_req;
   logic mode;
   logic ble_ready;
   logic owner;

   pmod_ble_ctrl_if cpu_if ();

   pmod_ble_ctrl #(
      .CLKS_PER_BIT (CPB),
      .RST_CYCLES   (RSTC),
      .BOOT_CYCLES  (BOOTC),
      .IDLE_BITS    (IDLEB)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_uart_rx       (uart_rx),
      .o_uart_tx       (uart_tx),
      .io_pmod_rxd     (pmod_rxd),
      .io_pmod_txd     (pmod_txd),
      .io_pmod_rstn    (pmod_rstn),
      .i_ble_reset_req (reset_req),
      .i_mode_cpu      (mode),
      .o_ble_ready     (ble_ready),
      .o_owner_cpu     (owner),
      .cpu             (cpu_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Behavioural model: cycles since sequence start, consecutive high host samples,
   // ownership flag, and the line values the serializer still has to emit.
   int m_seq;
   int m_run;
   bit m_owner;
   bit m_q[$];

   function automatic bit m_active();
      return m_seq >= RSTC + BOOTC;
   endfunction

   function automatic bit m_ready();
      return m_active() && m_owner && mode && (m_q.size() == 0);
   endfunction

   task automatic model_reset();
      m_seq   = 0;
      m_run   = 0;
      m_owner = 0;
      m_q.delete();
   endtask

   task automatic model_edge(input bit rx_s, input bit mode_s, input bit val_s,
                             input logic [7:0] d_s, input bit req_s);
      bit act, busy, acc;
      act  = m_active();
      busy = (m_q.size() != 0);
      acc  = act && m_owner && mode_s && !busy && val_s;
      m_run = rx_s ? m_run + 1 : 0;
      if (req_s) begin
         m_seq   = 0;
         m_owner = 0;
         m_q.delete();
      end else begin
         m_seq++;
         if (busy) void'(m_q.pop_front());
         if (acc) begin
            for (int i = 0; i < 10; i++) begin
               for (int k = 0; k < CPB; k++) begin
                  m_q.push_back(i == 0 ? 1'b0 : (i == 9 ? 1'b1 : d_s[i-1]));
               end
            end
         end
         if (!m_owner && act && mode_s && m_run >= IDLEB * CPB) m_owner = 1;
         else if (m_owner && !mode_s && !busy) m_owner = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      bit rx_s, mode_s, val_s, req_s;
      logic [7:0] d_s;
      rx_s   = uart_rx;
      mode_s = mode;
      val_s  = cpu_if.i_cpu_tx_valid;
      req_s  = reset_req;
      d_s    = cpu_if.i_cpu_tx_data;
      @(posedge clk);
      model_edge(rx_s, mode_s, val_s, d_s, req_s);
      #1;
   endtask

   task automatic check_all();
      bit line;
      line = (m_q.size() != 0) ? m_q[0] : 1'b1;
      chk("rstn", 32'(pmod_rstn), 32'(m_seq >= RSTC));
      chk("ble_ready", 32'(ble_ready), 32'(m_active()));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("pmod_rxd", 32'(pmod_rxd),
          32'(m_active() ? (m_owner ? line : uart_rx) : 1'b1));
      chk("tx_ready", 32'(cpu_if.o_cpu_tx_ready), 32'(m_ready()));
      chk("uart_tx_mirror", 32'(uart_tx), 32'(pmod_txd));
`ifndef PMOD_BLE_RXCAP_EN
      chk("rx_valid_tied", 32'(cpu_if.o_cpu_rx_valid), 32'd0);
      chk("rx_data_tied", 32'(cpu_if.o_cpu_rx_data), 32'd0);
`endif
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_all();
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      cpu_if.i_cpu_tx_data  = b;
      cpu_if.i_cpu_tx_valid = 1'b1;
      while (!m_ready() && guard < 200) begin
         step(1);
         guard++;
      end
      chk("send_wait_bound", 32'(guard < 200), 32'd1);
      step(1);
      cpu_if.i_cpu_tx_valid = 1'b0;
      cpu_if.i_cpu_tx_data  = 8'($urandom);
   endtask

   task automatic wait_owner();
      int guard;
      guard = 0;
      while (!m_owner && guard < 300) begin
         step(1);
         guard++;
      end
      chk("owner_wait_bound", 32'(owner), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [9:0] bits;
      logic [7:0] b;
      logic [7:0] got;
      int pulses;

      rst = 1'b1;
      uart_rx = 1'b1;
      pmod_txd = 1'b1;
      reset_req = 1'b0;
      mode = 1'b0;
      cpu_if.i_cpu_tx_data = '0;
      cpu_if.i_cpu_tx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("reset_rx_data", 32'(cpu_if.o_cpu_rx_data), 32'd0);
      chk("reset_rx_valid", 32'(cpu_if.o_cpu_rx_valid), 32'd0);
      check_all();

      // Boot sequence: rstn low 0..7, high from 8, ready at 24
      step(30);

      // Host passthrough and TX mirror with random line levels
      for (int i = 0; i < 24; i++) begin
         uart_rx  = 1'($urandom);
         pmod_txd = 1'($urandom);
         #1;
         check_all();
         step(1);
      end
      pmod_txd = 1'b1;

      // Takeover after idle run, with a glitch after 40 high cycles
      mode = 1'b1;
      uart_rx = 1'b0;
      step(1);
      uart_rx = 1'b1;
      step(40);
      uart_rx = 1'b0;
      step(1);
      uart_rx = 1'b1;
      step(43);
      chk("no_switch_at_43", 32'(owner), 32'd0);
      step(1);
      chk("switch_at_44", 32'(owner), 32'd1);

      // 0xA5 frame shape and ready-low length
      send_byte(8'hA5);
      cnt = 0;
      bits = '0;
      while (!cpu_if.o_cpu_tx_ready && cnt < 100) begin
         if (cnt % CPB == 0 && cnt / CPB < 10) bits[cnt / CPB] = pmod_rxd;
         step(1);
         cnt++;
      end
      chk("a5_ready_low_cycles", 32'(cnt), 32'd40);
      chk("a5_frame_bits", 32'(bits), 32'h34A);

      // Random bytes, with valid pulsed while busy (must be ignored)
      for (int n = 0; n < 3; n++) begin
         send_byte(8'($urandom));
         for (int i = 0; i < 45; i++) begin
            if (i == 5) begin
               cpu_if.i_cpu_tx_valid = 1'b1;
               cpu_if.i_cpu_tx_data  = 8'($urandom);
            end
            if (i == 11) cpu_if.i_cpu_tx_valid = 1'b0;
            step(1);
         end
      end

      // Mode drop mid-byte: byte completes, then owner returns to host
      send_byte(8'($urandom));
      step(15);
      mode = 1'b0;
      step(40);
      chk("owner_back_to_host", 32'(owner), 32'd0);

      // Reset request mid-byte
      mode = 1'b1;
      wait_owner();
      send_byte(8'($urandom));
      step(12);
      reset_req = 1'b1;
      step(1);
      reset_req = 1'b0;
      chk("req_rxd_high", 32'(pmod_rxd), 32'd1);
      chk("req_rstn_low", 32'(pmod_rstn), 32'd0);
      chk("req_owner_host", 32'(owner), 32'd0);
      step(30);

`ifdef PMOD_BLE_RXCAP_EN
      // Receiver: one good frame, then one frame with a bad stop bit
      pmod_txd = 1'b1;
      step(60);
      for (int f = 0; f < 2; f++) begin
         b = (f == 0) ? 8'h3C : 8'($urandom);
         pulses = 0;
         got = '0;
         for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < CPB; k++) begin
               pmod_txd = (i == 0) ? 1'b0 : (i == 9 ? (f == 0) : b[i-1]);
               step(1);
               if (cpu_if.o_cpu_rx_valid) begin
                  pulses++;
                  got = cpu_if.o_cpu_rx_data;
               end
            end
         end
         pmod_txd = 1'b1;
         for (int i = 0; i < 20; i++) begin
            step(1);
            if (cpu_if.o_cpu_rx_valid) begin
               pulses++;
               got = cpu_if.o_cpu_rx_data;
            end
         end
         if (f == 0) begin
            chk("rx_good_pulses", 32'(pulses), 32'd1);
            chk("rx_good_data", 32'(got), 32'h3C);
         end else begin
            chk("rx_badstop_pulses", 32'(pulses), 32'd0);
         end
      end
`endif

      // Global reset mid-byte
      wait_owner();
      send_byte(8'($urandom));
      step(10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_rstn", 32'(pmod_rstn), 32'd0);
      chk("rst_rxd", 32'(pmod_rxd), 32'd1);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_ble_ready", 32'(ble_ready), 32'd0);
      chk("rst_tx_ready", 32'(cpu_if.o_cpu_tx_ready), 32'd0);
      chk("rst_rx_data", 32'(cpu_if.o_cpu_rx_data), 32'd0);
      chk("rst_rx_valid", 32'(cpu_if.o_cpu_rx_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_all();
      step(30);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
